prog_seq: RTL and testbench

Parametrised program sequencer for the next-generation core: replaces the fixed 10-bit program counter with a unit that adds conditional relative branches, absolute jumps, a hardware call/return stack, a hardware loop counter, and an explicit Start/Ack run state machine with a cycle counter. It sits in the fetch stage, drives the instruction ROM address, and takes its per-cycle command from the control decoder.

---
 rtl/prog_seq_if.sv | 38 +++
 rtl/prog_seq.sv | 206 ++++++++++++++++++++
 tb/tb_prog_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_seq_if.sv
// prog_seq_if
// Connects the control decoder to the program sequencer.
//   Start   : request to (re)start the program from address 0
//   Halt    : current instruction is the halt instruction
//   PcOp    : sequencing command for the current instruction
//   Flag    : ALU branch flag for the current instruction
//   Target  : relative offset or absolute address from the instruction
//   ProgCtr : instruction ROM address
//   Ack     : program finished
//   Fault   : sticky call/return stack overflow or underflow
//   CycleCt : cycles spent running the current program
// The master modport belongs to the decoder side, the slave modport to the
// sequencer.
interface prog_seq_if #(
   parameter int PC_W  = 10,
   parameter int TGT_W = 8,
   parameter int CNT_W = 16
);
   logic             Start;
   logic             Halt;
   logic [2:0]       PcOp;
   logic             Flag;
   logic [TGT_W-1:0] Target;
   logic [PC_W-1:0]  ProgCtr;
   logic             Ack;
   logic             Fault;
   logic [CNT_W-1:0] CycleCt;

   modport master (
      output Start, Halt, PcOp, Flag, Target,
      input  ProgCtr, Ack, Fault, CycleCt
   );

   modport slave (
      input  Start, Halt, PcOp, Flag, Target,
      output ProgCtr, Ack, Fault, CycleCt
   );
endinterface

// File: rtl/prog_seq.sv
// prog_seq
// Program sequencer for the fetch stage. Produces the instruction ROM
// address each cycle from the decoder's sequencing command: increment,
// conditional relative branches, absolute jump, call/return through a
// hardware stack, and a hardware loop counter. A Start/Ack run state
// machine (IDLE, LOAD, RUN, DONE) frames each program run and a saturating
// counter records how many cycles were spent running.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   Bus   : prog_seq_if slave (Start/Halt/PcOp/Flag/Target in,
//           ProgCtr/Ack/Fault/CycleCt out, all outputs registered)
module prog_seq #(
   parameter int PC_W    = 10,
   parameter int TGT_W   = 8,
   parameter int STACK_D = 4,
   parameter int LOOP_W  = 8,
   parameter int CNT_W   = 16
) (
   input logic       Clk,
   input logic       Reset,
   prog_seq_if.slave Bus
);

   // Pointer must be able to hold STACK_D itself (stack full).
   localparam int SP_W = $clog2(STACK_D + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_BRT  = 3'b001;
   localparam logic [2:0] OP_BRF  = 3'b010;
   localparam logic [2:0] OP_JMP  = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;
   localparam logic [2:0] OP_LOOP = 3'b110;
   localparam logic [2:0] OP_SETL = 3'b111;

   // Sign-extend (or truncate) the target field to a PC-wide offset.
   function automatic logic [PC_W-1:0] sextTgt(input logic [TGT_W-1:0] t);
      return PC_W'($signed(t));
   endfunction

   // Zero-extend (or truncate) the target field to an absolute PC.
   function automatic logic [PC_W-1:0] zextTgt(input logic [TGT_W-1:0] t);
      return PC_W'(t);
   endfunction

   // Zero-extend (or truncate) the target field to a loop count.
   function automatic logic [LOOP_W-1:0] loopTgt(input logic [TGT_W-1:0] t);
      return LOOP_W'(t);
   endfunction

   logic [1:0]        stateR;
   logic [1:0]        stateNxtS;
   logic [PC_W-1:0]   pcR;
   logic [PC_W-1:0]   pcNxtS;
   logic [PC_W-1:0]   pcIncS;
   logic [PC_W-1:0]   pcRelS;
   logic [PC_W-1:0]   stackTopS;
   logic [LOOP_W-1:0] loopR;
   logic [LOOP_W-1:0] loopNxtS;
   logic [SP_W-1:0]   spR;
   logic [SP_W-1:0]   spNxtS;
   logic [PC_W-1:0]   stackR [STACK_D];
   logic              faultR;
   logic              faultNxtS;
   logic              ackR;
   logic [CNT_W-1:0]  cycR;
   logic [CNT_W-1:0]  cycNxtS;
   logic              pushS;
   logic              stackFullS;
   logic              stackEmptyS;

   // Relative offsets apply to the current PC, not PC+1; both wrap.
   assign pcIncS      = pcR + PC_W'(1);
   assign pcRelS      = pcR + sextTgt(Bus.Target);
   assign stackFullS  = (spR == SP_W'(STACK_D));
   assign stackEmptyS = (spR == {SP_W{1'b0}});

   // Select the top-of-stack entry (entry spR-1) without a narrow index.
   always_comb begin
      stackTopS = {PC_W{1'b0}};
      for (int i = 0; i < STACK_D; i++) begin
         stackTopS = (spR == SP_W'(i + 1)) ? stackR[i] : stackTopS;
      end
   end

   // Next-state and datapath decision for the current cycle.
   always_comb begin
      stateNxtS = stateR;
      pcNxtS    = pcR;
      loopNxtS  = loopR;
      spNxtS    = spR;
      faultNxtS = faultR;
      cycNxtS   = cycR;
      pushS     = 1'b0;
      if (Bus.Start) begin
         // Start wins in every state: hold everything cleared in LOAD.
         stateNxtS = S_LOAD;
         pcNxtS    = {PC_W{1'b0}};
         loopNxtS  = {LOOP_W{1'b0}};
         spNxtS    = {SP_W{1'b0}};
         faultNxtS = 1'b0;
         cycNxtS   = {CNT_W{1'b0}};
      end else begin
         case (stateR)
            S_IDLE: stateNxtS = S_IDLE;
            S_LOAD: stateNxtS = S_RUN;
            S_RUN: begin
               // The halt cycle and fault cycles count as run cycles too.
               cycNxtS = (cycR == {CNT_W{1'b1}}) ? cycR : cycR + CNT_W'(1);
               if (Bus.Halt) begin
                  stateNxtS = S_DONE;
               end else begin
                  case (Bus.PcOp)
                     OP_INC:  pcNxtS = pcIncS;
                     OP_BRT:  pcNxtS = Bus.Flag ? pcRelS : pcIncS;
                     OP_BRF:  pcNxtS = Bus.Flag ? pcIncS : pcRelS;
                     OP_JMP:  pcNxtS = zextTgt(Bus.Target);
                     OP_CALL: begin
                        if (stackFullS) begin
                           faultNxtS = 1'b1;
                           stateNxtS = S_DONE;
                        end else begin
                           pushS  = 1'b1;
                           spNxtS = spR + SP_W'(1);
                           pcNxtS = zextTgt(Bus.Target);
                        end
                     end
                     OP_RET: begin
                        if (stackEmptyS) begin
                           faultNxtS = 1'b1;
                           stateNxtS = S_DONE;
                        end else begin
                           spNxtS = spR - SP_W'(1);
                           pcNxtS = stackTopS;
                        end
                     end
                     OP_LOOP: begin
                        if (loopR != {LOOP_W{1'b0}}) begin
                           loopNxtS = loopR - LOOP_W'(1);
                           pcNxtS   = pcRelS;
                        end else begin
                           pcNxtS = pcIncS;
                        end
                     end
                     OP_SETL: begin
                        loopNxtS = loopTgt(Bus.Target);
                        pcNxtS   = pcIncS;
                     end
                     default: pcNxtS = pcIncS;
                  endcase
               end
            end
            S_DONE:  stateNxtS = S_DONE;
            default: stateNxtS = S_IDLE;
         endcase
      end
   end

   // Control and datapath registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateR <= S_IDLE;
         pcR    <= {PC_W{1'b0}};
         loopR  <= {LOOP_W{1'b0}};
         spR    <= {SP_W{1'b0}};
         faultR <= 1'b0;
         ackR   <= 1'b0;
         cycR   <= {CNT_W{1'b0}};
      end else begin
         stateR <= stateNxtS;
         pcR    <= pcNxtS;
         loopR  <= loopNxtS;
         spR    <= spNxtS;
         faultR <= faultNxtS;
         ackR   <= (stateNxtS == S_DONE);
         cycR   <= cycNxtS;
      end
   end

   // Call/return stack storage; a push writes the return address at spR.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < STACK_D; i++) begin
            stackR[i] <= {PC_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < STACK_D; i++) begin
            if (pushS && (spR == SP_W'(i))) begin
               stackR[i] <= pcIncS;
            end
         end
      end
   end

   assign Bus.ProgCtr = pcR;
   assign Bus.Ack     = ackR;
   assign Bus.Fault   = faultR;
   assign Bus.CycleCt = cycR;

endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq
// Self-checking bench for prog_seq. A behavioural model (integer PC with
// modulo arithmetic, a queue as the call stack, a named run mode) predicts
// every output after every clock; a table of vectors with hand-computed
// expected PC/Ack/Fault covers branches, wrap, call/return and the loop
// counter; hand-written sequences cover async reset, stack overflow and
// underflow; a random phase exercises everything against the model.
module tb_prog_seq;
   localparam int PC_W    = 10;
   localparam int TGT_W   = 8;
   localparam int STACK_D = 4;
   localparam int LOOP_W  = 8;
   localparam int CNT_W   = 16;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic Clk = 1'b0;
   logic Reset;

   prog_seq_if #(.PC_W(PC_W), .TGT_W(TGT_W), .CNT_W(CNT_W)) bus ();

   prog_seq #(
      .PC_W(PC_W), .TGT_W(TGT_W), .STACK_D(STACK_D),
      .LOOP_W(LOOP_W), .CNT_W(CNT_W)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Bus(bus)
   );

   always #5 Clk = ~Clk;

   int nCmp = 0;
   int nBad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int    mPc;
   int    mStk[$];
   int    mLoop;
   int    mCyc;
   bit    mAck;
   bit    mFault;
   string mMode;

   function automatic int wrap(input int x);
      return ((x % PC_MOD) + PC_MOD) % PC_MOD;
   endfunction

   function automatic void mReset();
      mPc = 0; mStk.delete(); mLoop = 0; mCyc = 0;
      mAck = 1'b0; mFault = 1'b0; mMode = "idle";
   endfunction

   function automatic void mFail();
      mFault = 1'b1; mAck = 1'b1; mMode = "done";
   endfunction

   function automatic void mStep(input bit st, input bit h, input int op, input bit fl, input int tgt);
      int rel;
      rel = (tgt >= 128) ? tgt - 256 : tgt;
      if (st) begin
         mMode = "load"; mPc = 0; mCyc = 0; mStk.delete();
         mLoop = 0; mFault = 1'b0; mAck = 1'b0;
         return;
      end
      if (mMode == "load") begin
         mMode = "run";
         return;
      end
      if (mMode != "run") return;
      if (mCyc < CNT_MAX) mCyc++;
      if (h) begin
         mMode = "done"; mAck = 1'b1;
         return;
      end
      case (op)
         0: mPc = wrap(mPc + 1);
         1: mPc = fl ? wrap(mPc + rel) : wrap(mPc + 1);
         2: mPc = fl ? wrap(mPc + 1) : wrap(mPc + rel);
         3: mPc = tgt;
         4: if (mStk.size() == STACK_D) mFail();
            else begin mStk.push_back(wrap(mPc + 1)); mPc = tgt; end
         5: if (mStk.size() == 0) mFail();
            else mPc = mStk.pop_back();
         6: if (mLoop != 0) begin mLoop--; mPc = wrap(mPc + rel); end
            else mPc = wrap(mPc + 1);
         default: begin mLoop = tgt; mPc = wrap(mPc + 1); end
      endcase
   endfunction

   // Apply one cycle of decoder inputs, clock, and check against the model.
   task automatic cyc(input bit st, input bit h, input int op, input bit fl, input int tgt, input string tag);
      bus.Start  = st;
      bus.Halt   = h;
      bus.PcOp   = 3'(op);
      bus.Flag   = fl;
      bus.Target = 8'(tgt);
      @(posedge Clk);
      mStep(st, h, op, fl, tgt);
      #1;
      chk({tag, " pc"},    32'(bus.ProgCtr), 32'(mPc));
      chk({tag, " ack"},   32'(bus.Ack),     32'(mAck));
      chk({tag, " fault"}, 32'(bus.Fault),   32'(mFault));
      chk({tag, " cycct"}, 32'(bus.CycleCt), 32'(mCyc));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit st; bit h; int op; bit fl; int tgt;
      int ePc; bit eAck; bit eFault;
   } vec_t;
   vec_t vt[$];

   function automatic void addV(input bit st, input bit h, input int op, input bit fl,
                                input int tgt, input int ePc, input bit eAck, input bit eFault);
      vec_t v;
      v.st = st; v.h = h; v.op = op; v.fl = fl; v.tgt = tgt;
      v.ePc = ePc; v.eAck = eAck; v.eFault = eFault;
      vt.push_back(v);
   endfunction

   initial begin
      // Branches around PC=20 with offset -4, then wrap both directions.
      addV(0,0,3,0, 20,  20,0,0);
      addV(0,0,1,1,252,  16,0,0);
      addV(0,0,3,0, 20,  20,0,0);
      addV(0,0,1,0,252,  21,0,0);
      addV(0,0,3,0, 20,  20,0,0);
      addV(0,0,2,0,252,  16,0,0);
      addV(0,0,3,0, 20,  20,0,0);
      addV(0,0,2,1,252,  21,0,0);
      addV(0,0,3,0,  0,   0,0,0);
      addV(0,0,1,1,255,1023,0,0);
      addV(0,0,0,0,  0,   0,0,0);
      // Nested call/return.
      addV(0,0,3,0, 10,  10,0,0);
      addV(0,0,4,0,100, 100,0,0);
      addV(0,0,4,0,200, 200,0,0);
      addV(0,0,5,0,  0, 101,0,0);
      addV(0,0,5,0,  0,  11,0,0);
      // Restart, SETL 3, body at 1, LOOP -1 at 2: body runs 4 times.
      addV(1,0,0,0,  0,   0,0,0);
      addV(0,0,0,0,  0,   0,0,0);
      addV(0,0,7,0,  3,   1,0,0);
      for (int k = 0; k < 3; k++) begin
         addV(0,0,0,0,  0,   2,0,0);
         addV(0,0,6,0,255,   1,0,0);
      end
      addV(0,0,0,0,  0,   2,0,0);
      addV(0,0,6,0,255,   3,0,0);
      // Halt, then Start held three cycles in DONE.
      addV(0,1,0,0,  0,   3,1,0);
      addV(1,0,0,0,  0,   0,0,0);
      addV(1,0,0,0,  0,   0,0,0);
      addV(1,0,0,0,  0,   0,0,0);
      addV(0,0,0,0,  0,   0,0,0);
      addV(0,0,0,0,  0,   1,0,0);

      // ---------------- reset state ----------------
      Reset = 1'b1;
      bus.Start = 1'b0; bus.Halt = 1'b0; bus.PcOp = 3'b000;
      bus.Flag = 1'b0; bus.Target = 8'h00;
      mReset();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst pc",    32'(bus.ProgCtr), 32'd0);
      chk("rst ack",   32'(bus.Ack),     32'd0);
      chk("rst fault", 32'(bus.Fault),   32'd0);
      chk("rst cycct", 32'(bus.CycleCt), 32'd0);
      Reset = 1'b0;
      cyc(0,0,0,0,0,"idle");
      cyc(0,0,0,0,0,"idle");

      // ---------------- async reset mid-RUN at PC=37 ----------------
      cyc(1,0,0,0,0,"start");
      cyc(0,0,0,0,0,"load");
      cyc(0,0,0,0,0,"inc");
      cyc(0,0,3,0,37,"jmp37");
      chk("jmp37 pc", 32'(bus.ProgCtr), 32'd37);
      #1 Reset = 1'b1;
      #1;
      chk("async rst pc",    32'(bus.ProgCtr), 32'd0);
      chk("async rst ack",   32'(bus.Ack),     32'd0);
      chk("async rst cycct", 32'(bus.CycleCt), 32'd0);
      mReset();
      @(posedge Clk);
      #1 Reset = 1'b0;
      cyc(1,0,0,0,0,"restart");
      cyc(0,0,0,0,0,"load");
      repeat (5) cyc(0,0,0,0,0,"inc5");
      cyc(0,1,0,0,0,"halt");
      chk("halt pc",    32'(bus.ProgCtr), 32'd5);
      chk("halt ack",   32'(bus.Ack),     32'd1);
      chk("halt cycct", 32'(bus.CycleCt), 32'd6);

      // ---------------- table vectors ----------------
      cyc(1,0,0,0,0,"tstart");
      cyc(0,0,0,0,0,"tload");
      foreach (vt[i]) begin
         cyc(vt[i].st, vt[i].h, vt[i].op, vt[i].fl, vt[i].tgt, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl pc", i),    32'(bus.ProgCtr), 32'(vt[i].ePc));
         chk($sformatf("vec%0d tbl ack", i),   32'(bus.Ack),     32'(vt[i].eAck));
         chk($sformatf("vec%0d tbl fault", i), 32'(bus.Fault),   32'(vt[i].eFault));
      end

      // ---------------- stack overflow and underflow ----------------
      cyc(1,0,0,0,0,"ovf start");
      cyc(0,0,0,0,0,"ovf load");
      cyc(0,0,4,0,10,"call1");
      cyc(0,0,4,0,20,"call2");
      cyc(0,0,4,0,30,"call3");
      cyc(0,0,4,0,40,"call4");
      chk("call4 fault", 32'(bus.Fault), 32'd0);
      cyc(0,0,4,0,50,"call5");
      chk("ovf pc",    32'(bus.ProgCtr), 32'd40);
      chk("ovf fault", 32'(bus.Fault),   32'd1);
      chk("ovf ack",   32'(bus.Ack),     32'd1);
      cyc(0,0,0,0,0,"ovf hold");
      cyc(1,0,0,0,0,"unf start");
      chk("unf fault clr", 32'(bus.Fault), 32'd0);
      cyc(0,0,0,0,0,"unf load");
      cyc(0,0,5,0,0,"ret empty");
      chk("unf pc",    32'(bus.ProgCtr), 32'd0);
      chk("unf fault", 32'(bus.Fault),   32'd1);
      chk("unf ack",   32'(bus.Ack),     32'd1);

      // ---------------- randomized against the model ----------------
      cyc(1,0,0,0,0,"rnd start");
      cyc(0,0,0,0,0,"rnd load");
      for (int n = 0; n < 800; n++) begin
         bit st;
         if (mMode == "done" || mMode == "idle")
            st = ($urandom_range(0, 3) == 0);
         else
            st = ($urandom_range(0, 99) == 0);
         cyc(st, ($urandom_range(0, 49) == 0), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
